// File: rtl/uart_rx_if.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// uart_rx_if : serial line, CPU read strobe and received-byte status bundle.
// Revision   : 1.0
// ---------------------------------------------------------------------------
interface uart_rx_if #(
   parameter int DATA_BITS = 8
);
   logic                 rxd;
   logic                 rdn;
   logic [DATA_BITS-1:0] d_out;
   logic                 r_ready;
   logic                 parity_error;
   logic                 frame_error;
   logic                 overrun;
   logic [3:0]           no_bits_rcvd;

   modport master (
      output rxd, rdn,
      input  d_out, r_ready, parity_error, frame_error, overrun, no_bits_rcvd
   );

   modport slave (
      input  rxd, rdn,
      output d_out, r_ready, parity_error, frame_error, overrun, no_bits_rcvd
   );
endinterface
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// uart_rx  : 16x oversampling UART receiver, 8E1 frames, CPU read strobe.
//            Optional 3-sample majority voting under UART_RX_MAJORITY_EN.
// Revision : 1.0
// ---------------------------------------------------------------------------
module uart_rx #(
   parameter int DATA_BITS = 8
) (
   input  wire logic clk16x,
   input  wire logic clrn,
   uart_rx_if.slave  bus
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      PARITY    = 3'd3,
      STOP      = 3'd4,
      WAIT_HIGH = 3'd5
   } state_t;

   state_t               state, state_nx;
   logic                 sync1, rxd_s;
   logic                 bit_val;
   logic [3:0]           cnt, cnt_nx;
   logic [3:0]           nbits, nbits_nx;
   logic [DATA_BITS-1:0] shreg, shreg_nx;
   logic                 par_s, par_nx;
   logic [DATA_BITS-1:0] dout_q, dout_nx;
   logic                 rdy_q, rdy_nx;
   logic                 pe_q, pe_nx;
   logic                 fe_q, fe_nx;
   logic                 ovr_q, ovr_nx;
   logic                 done;

   always_ff @(posedge clk16x or negedge clrn) begin
      if (!clrn) begin
         sync1 <= 1'b1;
         rxd_s <= 1'b1;
      end else begin
         sync1 <= bus.rxd;
         rxd_s <= sync1;
      end
   end

`ifdef UART_RX_MAJORITY_EN
   // Vote over the samples one before, at, and one after the bit centre.
   localparam logic [3:0] START_TAP = 4'd8;
   logic [1:0] hist;

   always_ff @(posedge clk16x or negedge clrn) begin
      if (!clrn) hist <= 2'b11;
      else       hist <= {hist[0], rxd_s};
   end

   assign bit_val = (rxd_s & hist[0]) | (rxd_s & hist[1]) | (hist[0] & hist[1]);
`else
   localparam logic [3:0] START_TAP = 4'd7;
   assign bit_val = rxd_s;
`endif

   always_ff @(posedge clk16x or negedge clrn) begin
      if (!clrn) begin
         state  <= IDLE;
         cnt    <= 4'd0;
         nbits  <= 4'd0;
         shreg  <= '0;
         par_s  <= 1'b0;
         dout_q <= '0;
         rdy_q  <= 1'b0;
         pe_q   <= 1'b0;
         fe_q   <= 1'b0;
         ovr_q  <= 1'b0;
      end else begin
         state  <= state_nx;
         cnt    <= cnt_nx;
         nbits  <= nbits_nx;
         shreg  <= shreg_nx;
         par_s  <= par_nx;
         dout_q <= dout_nx;
         rdy_q  <= rdy_nx;
         pe_q   <= pe_nx;
         fe_q   <= fe_nx;
         ovr_q  <= ovr_nx;
      end
   end

   // After the start check, cnt wraps every 16 ticks so each later decision lands on cnt=15.
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt + 4'd1;
      nbits_nx = nbits;
      shreg_nx = shreg;
      par_nx   = par_s;
      done     = 1'b0;
      case (state)
         IDLE: begin
            cnt_nx = 4'd0;
            if (!rxd_s) state_nx = START;
         end
         START: begin
            if (cnt == START_TAP) begin
               cnt_nx = 4'd0;
               if (bit_val) begin
                  state_nx = IDLE;
               end else begin
                  state_nx = DATA;
                  nbits_nx = 4'd1;
               end
            end
         end
         DATA: begin
            if (cnt == 4'hF) begin
               shreg_nx = {bit_val, shreg[DATA_BITS-1:1]};
               nbits_nx = nbits + 4'd1;
               if (nbits == 4'(DATA_BITS)) state_nx = PARITY;
            end
         end
         PARITY: begin
            if (cnt == 4'hF) begin
               par_nx   = bit_val;
               nbits_nx = nbits + 4'd1;
               state_nx = STOP;
            end
         end
         STOP: begin
            if (cnt == 4'hF) begin
               done     = 1'b1;
               nbits_nx = 4'd0;
               state_nx = bit_val ? IDLE : WAIT_HIGH;
            end
         end
         WAIT_HIGH: begin
            if (rxd_s) state_nx = IDLE;
         end
         default: begin
            state_nx = IDLE;
            nbits_nx = 4'd0;
         end
      endcase
   end

   // Frame completion takes priority over a CPU read on the same edge.
   always_comb begin
      dout_nx = dout_q;
      rdy_nx  = rdy_q;
      pe_nx   = pe_q;
      fe_nx   = fe_q;
      ovr_nx  = ovr_q;
      if (done) begin
         dout_nx = shreg;
         pe_nx   = (^shreg) != par_s;
         fe_nx   = !bit_val;
         ovr_nx  = rdy_q & bus.rdn;
         rdy_nx  = 1'b1;
      end else if (!bus.rdn) begin
         rdy_nx  = 1'b0;
         ovr_nx  = 1'b0;
      end
   end

   assign bus.d_out        = dout_q;
   assign bus.r_ready      = rdy_q;
   assign bus.parity_error = pe_q;
   assign bus.frame_error  = fe_q;
   assign bus.overrun      = ovr_q;
   assign bus.no_bits_rcvd = nbits;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_uart_rx : frame-level reference model with per-cycle output comparison.
// Revision   : 1.0
// ---------------------------------------------------------------------------
module tb_uart_rx;
   localparam int DATA_BITS = 8;
   // Cycles from the first drive of the start bit to the completion edge:
   // 3 edges through the synchroniser to t0, then t0+168 (t0+169 with voting).
`ifdef UART_RX_MAJORITY_EN
   localparam int LAT = 172;
`else
   localparam int LAT = 171;
`endif

   logic clk16x = 1'b0;
   logic clrn   = 1'b1;
   logic chk_en = 1'b0;

   uart_rx_if #(.DATA_BITS(DATA_BITS)) bus ();
   uart_rx #(.DATA_BITS(DATA_BITS)) dut (
      .clk16x (clk16x),
      .clrn   (clrn),
      .bus    (bus)
   );

   always #5 clk16x = ~clk16x;

   typedef struct {
      int       due;
      logic [7:0] data;
      logic     pe;
      logic     fe;
   } exp_t;

   exp_t       q[$];
   int         cyc    = 0;
   int         passed = 0;
   int         total  = 0;
   logic [7:0] m_dout = '0;
   logic       m_rdy  = 1'b0;
   logic       m_pe   = 1'b0;
   logic       m_fe   = 1'b0;
   logic       m_ovr  = 1'b0;

   // Reference: a pending frame lands on its due edge; otherwise a low rdn acknowledges.
   always @(posedge clk16x or negedge clrn) begin
      if (!clrn) begin
         m_dout <= '0;
         m_rdy  <= 1'b0;
         m_pe   <= 1'b0;
         m_fe   <= 1'b0;
         m_ovr  <= 1'b0;
         q.delete();
      end else begin
         cyc <= cyc + 1;
         if (q.size() > 0 && q[0].due == cyc + 1) begin
            m_dout <= q[0].data;
            m_pe   <= q[0].pe;
            m_fe   <= q[0].fe;
            m_ovr  <= m_rdy && bus.rdn;
            m_rdy  <= 1'b1;
            void'(q.pop_front());
         end else if (!bus.rdn) begin
            m_rdy  <= 1'b0;
            m_ovr  <= 1'b0;
         end
      end
   end

   always @(negedge clk16x) begin
      if (chk_en) begin
         total++;
         if ({bus.d_out, bus.r_ready, bus.parity_error, bus.frame_error, bus.overrun}
             === {m_dout, m_rdy, m_pe, m_fe, m_ovr})
            passed++;
         else
            $display("FAIL cycle_cmp cyc=%0d got d_out=%h rdy=%b pe=%b fe=%b ovr=%b want d_out=%h rdy=%b pe=%b fe=%b ovr=%b",
                     cyc, bus.d_out, bus.r_ready, bus.parity_error, bus.frame_error, bus.overrun,
                     m_dout, m_rdy, m_pe, m_fe, m_ovr);
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s got %h want %h", name, act, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk16x);
      #1;
   endtask

   task automatic idle(input int n);
      bus.rxd = 1'b1;
      tick(n);
   endtask

   task automatic read_pulse();
      bus.rdn = 1'b0;
      tick(1);
      bus.rdn = 1'b1;
   endtask

   // Called #1 after an edge. nbits < 11 aborts the frame without expecting it.
   task automatic send_frame(input logic [7:0] data, input logic par_flip, input logic stop,
                             input int nbits = 11, input int spike_bit = -1);
      logic [10:0] bits;
      logic        par_sent;
      par_sent = (^data) ^ par_flip;
      bits     = {stop, par_sent, data, 1'b0};
      if (nbits == 11)
         q.push_back('{due: cyc + LAT, data: data, pe: ((^data) != par_sent), fe: !stop});
      for (int b = 0; b < nbits; b++) begin
         for (int k = 0; k < 16; k++) begin
            bus.rxd = bits[b];
            if (b == spike_bit && k == 8) bus.rxd = ~bits[b];
            tick(1);
         end
      end
   endtask

   initial begin
      bus.rxd = 1'b1;
      bus.rdn = 1'b1;
      #2 clrn = 1'b0;
      chk_en  = 1'b1;
      tick(3);
      check("reset_nbits", 32'(bus.no_bits_rcvd), 32'd0);
      check("reset_ready", 32'(bus.r_ready), 32'd0);
      clrn = 1'b1;
      idle(5);

      // 1: clean frame then a single-cycle read
      send_frame(8'hA5, 1'b0, 1'b1);
      check("t1_dout", 32'(bus.d_out), 32'h0000_00A5);
      check("t1_ready", 32'(bus.r_ready), 32'd1);
      check("t1_flags", 32'({bus.parity_error, bus.frame_error, bus.overrun}), 32'd0);
      read_pulse();
      check("t1_read_ready", 32'(bus.r_ready), 32'd0);
      check("t1_read_dout", 32'(bus.d_out), 32'h0000_00A5);
      idle(4);

      // 2: wrong parity
      send_frame(8'h3C, 1'b1, 1'b1);
      check("t2_dout", 32'(bus.d_out), 32'h0000_003C);
      check("t2_pe", 32'(bus.parity_error), 32'd1);
      read_pulse();
      idle(4);

      // 3: framing error followed by a held break, then a good frame
      send_frame(8'h00, 1'b0, 1'b0);
      bus.rxd = 1'b0;
      tick(40);
      idle(20);
      check("t3_fe", 32'(bus.frame_error), 32'd1);
      read_pulse();
      idle(200);
      check("t3_no_second", 32'(bus.r_ready), 32'd0);
      send_frame(8'h81, 1'b0, 1'b1);
      check("t3_dout", 32'(bus.d_out), 32'h0000_0081);
      check("t3_fe_clear", 32'(bus.frame_error), 32'd0);
      read_pulse();
      idle(4);

      // 4: overrun, then rerun with the read on the completion edge
      send_frame(8'h55, 1'b0, 1'b1);
      send_frame(8'hAA, 1'b0, 1'b1);
      check("t4_dout", 32'(bus.d_out), 32'h0000_00AA);
      check("t4_ovr", 32'(bus.overrun), 32'd1);
      read_pulse();
      idle(4);
      send_frame(8'h55, 1'b0, 1'b1);
      fork
         send_frame(8'hAA, 1'b0, 1'b1);
         begin
            tick(LAT - 1);
            bus.rdn = 1'b0;
            tick(1);
            bus.rdn = 1'b1;
         end
      join
      check("t4_coinc_ready", 32'(bus.r_ready), 32'd1);
      check("t4_coinc_ovr", 32'(bus.overrun), 32'd0);
      read_pulse();
      idle(4);

      // 5: short glitch is a false start
      bus.rxd = 1'b0;
      tick(4);
      idle(30);
      check("t5_ready", 32'(bus.r_ready), 32'd0);
      check("t5_idle_nbits", 32'(bus.no_bits_rcvd), 32'd0);

      // 6: reset during data bit 4, then a fresh frame
      send_frame(8'h12, 1'b0, 1'b1, 5);
      clrn    = 1'b0;
      bus.rxd = 1'b1;
      tick(8);
      check("t6_rst_dout", 32'(bus.d_out), 32'd0);
      check("t6_rst_nbits", 32'(bus.no_bits_rcvd), 32'd0);
      clrn = 1'b1;
      idle(10);
      send_frame(8'h12, 1'b0, 1'b1);
      check("t6_dout", 32'(bus.d_out), 32'h0000_0012);
      check("t6_flags", 32'({bus.parity_error, bus.frame_error, bus.overrun}), 32'd0);
      read_pulse();
      idle(4);

`ifdef UART_RX_MAJORITY_EN
      send_frame(8'h5A, 1'b0, 1'b1, 11, 3);
      check("maj_spike_dout", 32'(bus.d_out), 32'h0000_005A);
      check("maj_spike_pe", 32'(bus.parity_error), 32'd0);
      read_pulse();
      idle(4);
`endif

      // Random frames with reads scattered through them
      for (int n = 0; n < 25; n++) begin
         logic [7:0] d;
         logic       flip, stp;
         d    = 8'($urandom);
         flip = ($urandom % 5) == 0;
         stp  = ($urandom % 6) != 0;
         fork
            send_frame(d, flip, stp);
            begin
               repeat ($urandom_range(1, 3)) begin
                  tick($urandom_range(10, 60));
                  bus.rdn = 1'b0;
                  tick($urandom_range(1, 3));
                  bus.rdn = 1'b1;
               end
            end
         join
         if (!stp || ($urandom % 2) == 0) idle($urandom_range(2, 8));
      end
      idle(200);

      chk_en = 1'b0;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver for the on-chip UART IO peripheral; pairs with the existing transmitter on the same line format.
- Frame: 1 start bit (0), 8 data bits LSB first, 1 even-parity bit (XOR of data), 1 stop bit (1).
- Oversamples `rxd` at 16x the bit rate, deserialises each frame, checks parity and stop, and holds the byte for the CPU.
- The CPU reads through an active-low read strobe.

Parameters:
- DATA_BITS, 8, number of data bits per frame. Parity is the XOR over all DATA_BITS.

Ports:
- clk16x  in  1  16x bit-rate clock. The only clock.
- clrn  in  1  asynchronous active-low reset.
- rxd  in  1  serial line, asynchronous to clk16x, idle high.
- rdn  in  1  active-low read strobe from the CPU, sampled on clk16x.
- d_out  out  DATA_BITS  last received byte.
- r_ready  out  1  byte available in d_out.
- parity_error  out  1  parity mismatch on the byte in d_out.
- frame_error  out  1  stop bit sampled 0 on the byte in d_out.
- overrun  out  1  a frame completed while r_ready was still 1.
- no_bits_rcvd  out  4  debug: bit index of the current frame (0 = start).

Behaviour:
- Reset:
  - clrn=0 clears all state asynchronously.
  - d_out=0, r_ready=0, parity_error=0, frame_error=0, overrun=0, no_bits_rcvd=0.
  - Internal synchroniser flops are set to 1. FSM goes to IDLE.
  - Reset mid-frame discards the partial frame.
- Input sync: rxd passes through 2 clk16x flops to give rxd_s. All decisions below use rxd_s.
- Tick counter cnt[3:0] runs in every non-IDLE state.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
- IDLE:
  - Let t0 be the first edge with rxd_s=0.
  - On t0: go to START, clear cnt.
- START:
  - At t0+8 (mid start bit), sample rxd_s.
  - If 1: false start; return to IDLE, nothing reported.
  - Else: go to DATA, clear cnt, no_bits_rcvd=1.
- DATA:
  - Bit i (i=0..7) is sampled at t0+8+16*(i+1) into shift register position i (LSB first).
  - no_bits_rcvd increments after each sample.
- PARITY: sampled at t0+152.
- STOP:
  - Stop bit sampled at t0+168.
  - On that same edge the outputs update:
    - d_out = shift register.
    - parity_error = (XOR of data) != parity sample.
    - frame_error = !stop sample.
    - overrun = 1 if r_ready was 1 and rdn was high on that edge, else 0.
    - r_ready = 1.
  - If stop sample = 1: go to IDLE. A new start can be detected from t0+169.
  - If stop sample = 0: go to WAIT_HIGH, leaving it on the first edge with rxd_s=1. This stops a break condition from retriggering.
- Read handshake:
  - Any edge with rdn=0 and no frame completing clears r_ready and overrun.
  - d_out and the error flags hold until the next frame completes.
  - rdn held low for many cycles is harmless.
- Simultaneous frame completion and rdn=0: completion wins. r_ready=1 with the new data; overrun=0.
- Error flags describe only the frame currently in d_out and are rewritten on every completion.

Optional Feature:
- Macro UART_RX_MAJORITY_EN.
- Defined:
  - Every bit decision (start check, data, parity, stop) uses the majority of the rxd_s samples at cnt=7, 8 and 9.
  - The decision edge stays at cnt=8+1, so all sample times above shift by +1 cycle, including the output update at t0+169.
- Undefined: single sample at cnt=8 exactly as timed above. No extra flops.

Test Plan:
1. Reset, then send 0xA5 with parity 0 and stop 1 at 16 clk16x per bit.
   - Required: d_out=0xA5, r_ready=1 at t0+168, parity_error=0, frame_error=0, overrun=0.
   - Then pulse rdn low for 1 cycle. Required: r_ready=0, d_out still 0xA5.
2. Send 0x3C with parity 1 (wrong; correct is 0). Required: d_out=0x3C, r_ready=1, parity_error=1.
3. Send 0x00 with stop bit 0, then hold rxd low for 40 cycles, then high.
   - Required: frame_error=1, and no second frame is reported.
   - Next frame 0x81 is received correctly with frame_error=0.
4. Send 0x55 then 0xAA back-to-back without reading.
   - Required: d_out=0xAA, overrun=1.
   - Assert rdn exactly on the 0xAA completion edge in a rerun. Required: r_ready=1, overrun=0.
5. Drive a 4-cycle low glitch on an idle rxd. Required: false start; FSM back in IDLE, r_ready stays 0.
6. Assert clrn low at data bit 4 of a frame, release, then send 0x12.
   - Required: all outputs 0 during reset, then d_out=0x12 with no error flags.
   - With UART_RX_MAJORITY_EN defined: a 1-cycle inverted spike at cnt=8 of a data bit does not corrupt the byte.
